avalon_ram_ws: RTL and testbench
================================

# avalon_ram_ws

Parametrised Avalon-MM slave RAM model that replaces the fixed single-cycle test memory used by the CPU benches. It adds a configurable wait-state count, a base-address window, byte-enable writes, and a side-band preload port for loading programs before or during a run. It also provides sticky bus-error reporting and an access counter. It sits between `top_level_CPU` and the testbench; it is bench infrastructure and is not synthesised into the CPU.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 2: cycles of waitrequest=1 before each access completes (0..15).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to 4·depth.
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  Avalon byte address.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  per-byte write enable; bit n controls writedata[8n+7:8n].
- `waitrequest`  out  1  stall: the master holds all request signals stable while this is 1.
- `readdata`  out  32  read data, valid only in the cycle read=1 and waitrequest=0.
- `load_en`  in  1  preload-port write strobe.
- `load_addr`  in  ADDR_WIDTH  preload word index.
- `load_data`  in  32  preload word; all 4 bytes are written.
- `bus_err`  out  1  sticky error flag.
- `access_count`  out  32  number of completed bus accesses.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On read|write with WAIT_STATES=0: complete in the same cycle. waitrequest=0, readdata is combinational from the array, and a write commits at the clock edge. The FSM stays in IDLE.
  - On read|write with WAIT_STATES>0: latch address, go to WAIT, load the counter with WAIT_STATES-1.
- WAIT: waitrequest=1; the counter decrements; at 0 go to DONE.
- DONE: waitrequest=0; readdata is driven from the array; a write commits at the edge; access_count increments; return to IDLE.
- A request is "in range" when `address` is between BASE_ADDR and BASE_ADDR+4·depth-1 and address[1:0]==0.
- Out-of-range or misaligned request: full wait-state timing, readdata=0, write dropped, bus_err set.
- read and write both 1: treated as an error, no array access, bus_err set, normal completion timing.
- Write merge: only bytes with byteenable=1 change. byteenable=0 with write=1 is a legal no-op access and is counted.
- Preload conflict: load_en writes `mem[load_addr]` at the edge and has priority. If a bus write would commit in the same cycle, DONE is held one extra cycle (waitrequest=1), and the bus write commits next cycle. Bus write data therefore wins over the preload value in that case.
- A bus read completing in the same cycle as a preload to the same word returns the pre-write (old) value.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - waitrequest = 1 while reset is low.
  - readdata = 0, bus_err = 0, access_count = 0.
- Read latency: WAIT_STATES cycles of waitrequest=1, then 1 data cycle. With WAIT_STATES=0 the read completes in zero extra cycles.
- Back-to-back requests: the earliest a new request can start is the cycle after DONE. A request asserted in DONE's following IDLE cycle is accepted.
- access_count wraps modulo 2^32.
- Reset asserted mid-access: the access is aborted with no array write, and the FSM returns to IDLE asynchronously.
- Dropping read/write while waitrequest=1 is a master protocol violation: the FSM returns to IDLE, bus_err is set, and nothing is counted.

## Structure
- Package `avalon_ram_pkg`: the FSM state enum (IDLE/WAIT/DONE) and the byte-merge function taking (old word, writedata, byteenable) and returning the merged word.
- Sub-module `wait_counter`: a loadable down-counter with a zero flag, parametrised on WAIT_STATES width.
- Array and preload arbitration stay in the top module.

## Test plan
- WAIT_STATES=2, preload 0x24420010 at word 1, then read address 0x04 → waitrequest high 2 cycles, then readdata=0x24420010 in cycle 3, access_count=1.
- Write 0xAABBCCDD to 0x08 with byteenable=4'b0101 over old value 0x11223344 → a following read returns 0x11BB33DD.
- Read 0x0000_1000 with ADDR_WIDTH=10 → readdata=0, bus_err=1 after completion, the array is unchanged.
- Preload word 2 = 0x0 in the same cycle a bus write of 0x55 to 0x08 commits → one extra waitrequest cycle, then a read of 0x08 returns 0x55.
- WAIT_STATES=0, ten back-to-back reads → waitrequest never asserted, access_count=10.
- Assert reset during WAIT of a write to 0x0C → waitrequest=1 during reset, word 3 keeps its old value, counters=0.

Source files
------------

// File: rtl/avalon_ram_pkg.sv
`default_nettype none
// ============================================================================
// Package : avalon_ram_pkg
// Shared FSM state encoding and byte-lane merge for avalon_ram_ws.
// Rev     : 1.0
// ============================================================================
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_WIDTH = 4;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_ram_ws_wait_counter.sv
`default_nettype none
// ============================================================================
// Module : wait_counter
// Loadable down-counter with zero and last-step flags; saturates at zero.
// Rev    : 1.0
// ============================================================================
module wait_counter
    import avalon_ram_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
    assign last = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/avalon_ram_ws.sv
`default_nettype none
// ============================================================================
// Module : avalon_ram_ws
// Avalon-MM slave RAM with wait states, byte enables, preload port and error flag.
// Rev    : 1.0
// ============================================================================
module avalon_ram_ws
    import avalon_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  bus_err,
    output logic [31:0]           access_count
);

    localparam int c_depth = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_ws_load =
        (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_e                state_d, state_q;
    logic [31:0]           addr_d, addr_q;
    logic                  bus_err_d, bus_err_q;
    logic [31:0]           count_d, count_q;
    logic                  active_q;
    logic [31:0]           mem_q [c_depth];

    logic [31:0]           use_addr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  req, in_range, acc_ok, bus_wr, bus_we;
    logic                  complete, hold, viol;
    logic                  cnt_load, cnt_dec, cnt_zero, cnt_last;

    // Address is taken live in IDLE (zero-wait completion) and from the latch afterwards.
    assign use_addr = (state_q == IDLE) ? address : addr_q;
    assign word_idx = use_addr[ADDR_WIDTH+1:2];
    assign in_range = (use_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) &&
                      (use_addr[1:0] == 2'b00);
    assign req      = read | write;
    assign acc_ok   = in_range && !(read && write);
    assign bus_wr   = write && !read && acc_ok;

    wait_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (c_ws_load),
        .dec        (cnt_dec),
        .zero       (cnt_zero),
        .last       (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        complete = 1'b0;
        hold     = 1'b0;
        viol     = 1'b0;
        if (active_q) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            if (bus_wr && load_en) begin
                                hold = 1'b1;
                            end else begin
                                complete = 1'b1;
                            end
                        end else begin
                            addr_d   = address;
                            cnt_load = 1'b1;
                            state_d  = (WAIT_STATES == 1) ? DONE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        viol    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                        if (cnt_last || cnt_zero) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // A preload in the commit cycle wins the array; the bus write retries next cycle.
                    if (!req) begin
                        state_d = IDLE;
                    end else if (bus_wr && load_en) begin
                        hold = 1'b1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        waitrequest = 1'b1;
        if (active_q) begin
            case (state_q)
                IDLE:    waitrequest = req && ((WAIT_STATES != 0) || hold);
                WAIT:    waitrequest = 1'b1;
                DONE:    waitrequest = hold;
                default: waitrequest = 1'b1;
            endcase
        end
    end

    assign bus_we    = complete && bus_wr;
    assign bus_err_d = bus_err_q | viol | (complete && !acc_ok);
    assign count_d   = count_q + {31'b0, complete};

    // active_q keeps the slave stalled until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            bus_err_q <= 1'b0;
            count_q   <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bus_err_q <= bus_err_d;
            count_q   <= count_d;
            active_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end else if (bus_we) begin
            mem_q[word_idx] <= byte_merge(mem_q[word_idx], writedata, byteenable);
        end
    end

    assign readdata     = (complete && read && !write && in_range) ? mem_q[word_idx] : '0;
    assign bus_err      = bus_err_q;
    assign access_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram_ws.sv
`default_nettype none
// ============================================================================
// Module : tb_avalon_ram_ws
// Scoreboarded random and directed bench for avalon_ram_ws (WS=2 and WS=0).
// Rev    : 1.0
// ============================================================================
module tb_avalon_ram_ws;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   address = '0, writedata = '0;
    logic          read = 1'b0, write = 1'b0;
    logic [3:0]    byteenable = '0;
    logic          waitrequest, bus_err;
    logic [31:0]   readdata, access_count;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    logic [31:0]   address0 = '0, writedata0 = '0;
    logic          read0 = 1'b0, write0 = 1'b0;
    logic [3:0]    byteenable0 = '0;
    logic          waitrequest0, bus_err0;
    logic [31:0]   readdata0, access_count0;

    avalon_ram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .bus_err(bus_err), .access_count(access_count)
    );

    avalon_ram_ws #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .reset(reset), .address(address0), .read(read0), .write(write0),
        .writedata(writedata0), .byteenable(byteenable0), .waitrequest(waitrequest0),
        .readdata(readdata0), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .bus_err(bus_err0), .access_count(access_count0)
    );

    typedef struct {
        logic [31:0] data;
        bit          is_read;
        int          waits;
        logic [31:0] cnt;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] q0[$];
    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];
    logic [31:0] m_count;
    bit          m_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one bus access; optionally pulse the preload port in cycle pl_cycle of it.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int pl_cycle,
                          input logic [AW-1:0] pl_idx, input logic [31:0] pl_data);
        exp_t        e;
        bit          ok, done;
        int          idx, k;
        logic [31:0] off, mask;
        off  = addr - BASE;
        ok   = (addr >= BASE) && (off < 4 * DEPTH) && (addr[1:0] == 2'b00) && !(rd && wr);
        idx  = ok ? int'(off[AW+1:2]) : 0;
        e.is_read = rd;
        e.data    = (rd && ok) ? model[idx] : 32'h0;
        e.waits   = ((pl_cycle == WS) && wr && !rd && ok) ? WS + 1 : WS;
        if (pl_cycle >= 0) begin
            model[pl_idx]  = pl_data;
            model0[pl_idx] = pl_data;
        end
        if (wr && ok) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            model[idx] = (model[idx] & ~mask) | (wd & mask);
        end
        m_count = m_count + 1;
        if (!ok) m_err = 1'b1;
        e.cnt = m_count;
        e.err = m_err;
        sb_q.push_back(e);

        address = addr; read = rd; write = wr; writedata = wd; byteenable = be;
        load_addr = pl_idx; load_data = pl_data; load_en = (pl_cycle == 0);
        done = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (!waitrequest) done = 1'b1;
            @(posedge clk); #1;
            k++;
            load_en = (k == pl_cycle);
        end
        load_en = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, k);
        end
    endtask

    initial begin : mon
        int   wcnt;
        bit   pend;
        exp_t cur;
        wcnt = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("access_count", access_count, cur.cnt);
                check("bus_err", {31'b0, bus_err}, {31'b0, cur.err});
                pend = 1'b0;
            end
            if (!reset || !(read || write)) begin
                wcnt = 0;
            end else if (waitrequest) begin
                wcnt++;
            end else begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: addr %h expected none", address);
                end else begin
                    cur = sb_q.pop_front();
                    if (cur.is_read) check("readdata", readdata, cur.data);
                    check("wait_cycles", 32'(wcnt), 32'(cur.waits));
                    pend = 1'b1;
                end
                wcnt = 0;
            end
        end
    end

    initial begin : mon0
        logic [31:0] e0;
        forever begin
            @(negedge clk);
            if (read0 && reset) begin
                check("ws0_waitrequest", {31'b0, waitrequest0}, 32'd0);
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ws0_unexpected_read: got %h expected none", readdata0);
                end else begin
                    e0 = q0.pop_front();
                    check("ws0_readdata", readdata0, e0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a, d;
        logic [3:0]  be;
        int          kind;
        m_count = '0;
        m_err   = 1'b0;

        // Preload the whole array while reset is held; the preload port ignores reset.
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            d = (i == 1) ? 32'h2442_0010 : (i == 2) ? 32'h1122_3344 : $urandom;
            load_en = 1'b1; load_addr = AW'(i); load_data = d;
            model[i]  = d;
            model0[i] = d;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        @(negedge clk);
        check("reset_waitrequest", {31'b0, waitrequest}, 32'd1);
        check("reset_readdata", readdata, 32'h0);
        check("reset_bus_err", {31'b0, bus_err}, 32'd0);
        check("reset_access_count", access_count, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        access(1, 0, 32'h04, 0, 4'h0, -1, '0, 0);
        access(0, 1, 32'h08, 32'hAABB_CCDD, 4'b0101, -1, '0, 0);
        access(1, 0, 32'h08, 0, 4'h0, -1, '0, 0);
        check("merge_model", model[2], 32'h11BB_33DD);
        access(1, 0, 32'h1000, 0, 4'h0, -1, '0, 0);
        access(1, 0, 32'h00, 0, 4'h0, -1, '0, 0);
        access(0, 1, 32'h08, 32'h55, 4'hF, WS, AW'(2), 32'h0);
        access(1, 0, 32'h08, 0, 4'h0, -1, '0, 0);
        access(1, 0, 32'h10, 0, 4'h0, WS, AW'(4), 32'hDEAD_BEEF);
        access(1, 0, 32'h10, 0, 4'h0, -1, '0, 0);
        access(0, 1, 32'h14, 32'hFFFF_FFFF, 4'h0, -1, '0, 0);
        access(1, 0, 32'h14, 0, 4'h0, -1, '0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, DEPTH - 1)) << 2;
            d    = $urandom;
            be   = 4'($urandom_range(0, 15));
            case (kind)
                0, 1, 2, 3: access(1, 0, a, 0, 4'h0, -1, '0, 0);
                4, 5, 6:    access(0, 1, a, d, be, -1, '0, 0);
                7:          access(1, 0, 32'h1000 + a, 0, 4'h0, -1, '0, 0);
                8:          access(0, 1, a | 32'($urandom_range(1, 3)), d, 4'hF, -1, '0, 0);
                default:    access(1, 1, a, d, 4'hF, -1, '0, 0);
            endcase
        end

        // Reset in the middle of a write: nothing commits and the counters clear.
        address = 32'h0C; writedata = 32'hCAFE_F00D; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_waitrequest", {31'b0, waitrequest}, 32'd1);
        check("midreset_access_count", access_count, 32'h0);
        check("midreset_bus_err", {31'b0, bus_err}, 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        reset = 1'b1;
        m_count = '0;
        m_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        access(1, 0, 32'h0C, 0, 4'h0, -1, '0, 0);

        // Master drops read while stalled: error raised, nothing counted.
        address = 32'h04; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        m_err = 1'b1;
        @(negedge clk);
        check("viol_bus_err", {31'b0, bus_err}, 32'd1);
        check("viol_access_count", access_count, m_count);
        @(posedge clk); #1;
        access(1, 0, 32'h04, 0, 4'h0, -1, '0, 0);

        // Zero-wait instance: ten back-to-back reads.
        for (int n = 0; n < 10; n++) begin
            a = 32'($urandom_range(0, DEPTH - 1));
            q0.push_back(model0[a]);
            address0 = a << 2;
            read0    = 1'b1;
            @(posedge clk); #1;
        end
        read0 = 1'b0;
        @(negedge clk);
        check("ws0_access_count", access_count0, 32'd10);
        check("ws0_bus_err", {31'b0, bus_err0}, 32'd0);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size() + q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
